dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the data-side memory interface driven by the execute stage.
- Accepts one load/store request at a time from a held-valid initiator. Performs it on an internal word-addressed RAM after a configurable number of wait states.
- Returns a single-cycle registered ready pulse carrying read data and an access-fault flag.
- Sits between the execute stage and the core's tightly-coupled data RAM.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words (window = 4*2^DEPTH_LOG2 bytes).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to the window size.
- WAIT_CYCLES, 1, extra wait states per access, 0..15.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- mem_valid  in  1  request valid; initiator holds it and all request fields stable until mem_ready.
- mem_store  in  1  1 = store, 0 = load.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_strb  in  4  byte enables, meaningful for loads and stores.
- mem_ready  out  1  one-cycle response pulse.
- mem_error  out  1  access fault; valid only when mem_ready=1.
- mem_rdata  out  32  full RAM word; valid only when mem_ready=1 and load.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, counter=0, mem_ready=0, mem_error=0, mem_rdata=0, latched request cleared. RAM contents are not reset.
- Reset applied mid-transaction aborts it: no RAM write, no ready pulse.
- States: IDLE and BUSY.
- IDLE:
  - If mem_valid=1 and mem_ready=0, latch store/addr/wdata/strb, load counter with WAIT_CYCLES, go to BUSY.
  - The mem_ready=0 guard prevents re-accepting the request the initiator is still holding during its ready cycle.
- BUSY, mem_valid=0: abort (trap or flush upstream). Go to IDLE; no write, no pulse.
- BUSY, counter≠0: decrement the counter.
- BUSY, counter=0: perform the access and go to IDLE. At that edge register mem_ready=1 and mem_error=fault.
  - Load, no fault: mem_rdata = RAM[index].
  - Store, no fault: write RAM[index] byte lanes where strb=1; mem_rdata=0.
  - Fault: no write; mem_rdata=0.
- Outputs default to 0 in every other cycle, so mem_ready is never high for two consecutive cycles.
- Index = (latched_addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
- fault = addr < BASE_ADDR, or addr >= BASE_ADDR + 4*2^DEPTH_LOG2, or strb = 0. Compare in 33-bit arithmetic so the top of the window does not wrap.
- Latency: valid sampled at edge N (acceptance), mem_ready high in cycle N+2+WAIT_CYCLES. Throughput is one request per WAIT_CYCLES+3 cycles.
- Address bits [1:0] are ignored for indexing; lane selection is by strb only.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- When defined, fault additionally covers these cases:
  - strb not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - strb=1111 with addr[1:0]≠0.
  - Halfword strb with addr[0]≠0.
- Misaligned stores are not written.
- When undefined, only the range check and strb≠0 apply.

Decomposition:
- Shared package (constants/wires):
  - dmem_state_type enum {IDLE, BUSY}.
  - dmem_responder_reg_type struct (state, counter, latched request, ready, error, rdata).
  - init_dmem_responder_reg constant.
  - dmem_req_type / dmem_rsp_type structs matching the port groups.
- One sub-module, dmem_ram: single-port synchronous RAM with byte-write enables, 1-cycle read. It holds the storage array; the FSM and range/alignment checks stay in dmem_responder.

Test Plan:
- Reset mid-store:
  - Stimulus: WAIT_CYCLES=3; store 0xDEADBEEF strb 1111 to 0x8000_0010; assert reset=0 one cycle after acceptance; release; then load 0x8000_0010.
  - Required response: load returns the prior contents, and no mem_ready appears before the reset.
- Store then load:
  - Stimulus: WAIT_CYCLES=1; store 0x12345678 strb 1111 at 0x8000_0000, then load the same address.
  - Required response: each mem_ready arrives 3 cycles after acceptance with error=0; load rdata=0x12345678.
- Partial stores:
  - Stimulus: strb 0100 wdata 0x00AB0000 to 0x8000_0002, then strb 0011 wdata 0x0000CDEF to 0x8000_0000, then load.
  - Required response: rdata = 0x12ABCDEF.
- Out-of-range accesses:
  - Stimulus: load 0x7FFF_FFFC; store to 0x8000_4000 (DEPTH_LOG2=12).
  - Required response: mem_ready with error=1, rdata=0, and RAM at index 0 unchanged.
- Abort and back-to-back:
  - Stimulus: drop mem_valid while BUSY (WAIT_CYCLES=2), then hold valid across two consecutive requests.
  - Required response: no pulse for the aborted request; exactly one pulse per request; ready never asserted in adjacent cycles.
- Misalignment check:
  - Stimulus: with DMEM_MISALIGN_CHECK_EN, store strb 1111 at 0x8000_0002.
  - Required response: error=1, no write.
  - Without the macro: error=0, write to index 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state, request/response groups,
// register record and its reset value. Optional build macro: DMEM_MISALIGN_CHECK_EN.
package dmem_responder_pkg;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = STATE_IDLE,
    BUSY = STATE_BUSY
  } dmem_state_type;

  typedef struct packed {
    logic        valid;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } dmem_req_type;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } dmem_rsp_type;

  typedef struct packed {
    dmem_state_type state;
    logic [3:0]     counter;
    logic           store;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [3:0]     strb;
    logic           ready;
    logic           error;
    logic [31:0]    rdata;
  } dmem_responder_reg_type;

  localparam dmem_responder_reg_type init_dmem_responder_reg = '{
    state:   IDLE,
    counter: '0,
    store:   1'b0,
    addr:    '0,
    wdata:   '0,
    strb:    '0,
    ready:   1'b0,
    error:   1'b0,
    rdata:   '0
  };

  // Byte lanes may sit anywhere; halfwords need an even address, words a 4-byte one.
  function automatic logic strb_misaligned(input logic [3:0] strb, input logic [1:0] lsb);
    logic bad;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
      4'b0011, 4'b1100:                   bad = lsb[0];
      4'b1111:                            bad = |lsb;
      default:                            bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 32-bit words, per-byte write enables,
// one-cycle registered read.
module dmem_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one held-valid request, waits WAIT_CYCLES, then
// performs it on the local RAM and returns a one-cycle ready pulse. Optional: DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_store,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_strb,
  output logic        mem_ready,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'd4 << DEPTH_LOG2);

  dmem_req_type           req;
  dmem_rsp_type           rsp;
  dmem_responder_reg_type r, rin;

  logic                  fault;
  logic                  access;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] ram_index;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  assign req = '{valid: mem_valid, store: mem_store, addr: mem_addr,
                 wdata: mem_wdata, strb: mem_strb};

  always_comb begin
    fault = ({1'b0, r.addr} < BASE_EXT) || ({1'b0, r.addr} >= LIMIT_EXT) || (r.strb == 4'b0000);
`ifdef DMEM_MISALIGN_CHECK_EN
    fault = fault || strb_misaligned(r.strb, r.addr[1:0]);
`endif
  end

  // The RAM is read from the live address at acceptance and from the latched one
  // while busy, so the word is already registered when the access edge arrives,
  // even with zero wait states.
  assign offset    = ((r.state == IDLE) ? req.addr : r.addr) - BASE_ADDR;
  assign ram_index = DEPTH_LOG2'(offset >> 2);
  assign access    = (r.state == BUSY) && req.valid && (r.counter == 4'd0);
  assign ram_we    = (reset && access && r.store && !fault) ? r.strb : 4'b0000;

  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_index),
    .wdata (r.wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    rin       = r;
    rin.ready = 1'b0;
    rin.error = 1'b0;
    rin.rdata = '0;
    case (r.state)
      IDLE: begin
        if (req.valid && !r.ready) begin
          rin.state   = BUSY;
          rin.counter = 4'(WAIT_CYCLES);
          rin.store   = req.store;
          rin.addr    = req.addr;
          rin.wdata   = req.wdata;
          rin.strb    = req.strb;
        end
      end
      BUSY: begin
        if (!req.valid) begin
          rin.state = IDLE;
        end else if (r.counter != 4'd0) begin
          rin.counter = r.counter - 4'd1;
        end else begin
          rin.state = IDLE;
          rin.ready = 1'b1;
          rin.error = fault;
          rin.rdata = (!fault && !r.store) ? ram_rdata : '0;
        end
      end
      default: rin = init_dmem_responder_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r <= init_dmem_responder_reg;
    else        r <= rin;
  end

  assign rsp       = '{ready: r.ready, error: r.error, rdata: r.rdata};
  assign mem_ready = rsp.ready;
  assign mem_error = rsp.error;
  assign mem_rdata = rsp.rdata;

endmodule
